// File: rtl/fetch_sequence_q.sv
// rtl/fetch_sequence_q.sv - fetch PC sequencer with miss/uncached locking, BTB redirect and output queue
// Issues fetch PCs, tracks one F1 stage, and queues hit PCs with fetch ids toward decode.
module fetch_sequence_q #(
  parameter logic [31:0] STARTUP_PC = 32'h8000_0000,
  parameter int          FID_W      = 8,
  parameter int          QDEPTH     = 4,
  parameter int          QAW        = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             bco_valid,
  input  logic [31:0]      bco_target,
  input  logic             snoop_hit,
  input  logic [31:0]      snoop_addr,
  input  logic             cache_hit,
  input  logic             cache_uncached,
  input  logic             cache_refilled_hit,
  input  logic             cache_uncached_done,
  input  logic             bp_valid,
  input  logic             bp_taken,
  input  logic             bp_hit,
  input  logic [31:0]      bp_target,
  output logic             cctrl_miss,
  output logic             cctrl_uncached,
  output logic [31:0]      pc_vaddr,
  output logic [31:0]      pc_paddr,
  output logic             pc_uncached,
  output logic             pc_valid,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_pc_vaddr,
  output logic [FID_W-1:0] o_pc_fid,
  output logic             o_pc_bp_taken,
  output logic [QAW:0]     o_count
);

  localparam int CW = QAW + 1;

  typedef enum logic {SEQ, LOCKED} state_e;

  state_e             state_q;
  logic [31:0]        pc0_q;
  logic [31:0]        f1_pc_q;
  logic [FID_W-1:0]   fid_q;
  logic [FID_W-1:0]   f1_fid_q;
  logic               f1_valid_q;
  logic               cctrl_miss_q;
  logic               cctrl_uncached_q;
  logic [31:0]        q_pc_q  [QDEPTH];
  logic [FID_W-1:0]   q_fid_q [QDEPTH];
  logic [QDEPTH-1:0]  q_bp_q;
  logic [QAW-1:0]     wr_ptr_q;
  logic [QAW-1:0]     rd_ptr_q;
  logic [CW-1:0]      count_q;

  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               pred_taken;
  logic               f1_hit;
  logic               f1_miss;
  logic               lock_done;
  logic               issue;
  logic               push;
  logic               pop;
  logic [31:0]        push_pc;
  logic [31:0]        pc_seq_d;

  assign redirect    = snoop_hit | bco_valid;
  assign redirect_pc = snoop_hit ? snoop_addr : bco_target;
  assign pred_taken  = bp_valid & bp_hit & bp_taken;
  assign f1_hit      = (state_q == SEQ) & f1_valid_q & cache_hit;
  assign f1_miss     = (state_q == SEQ) & f1_valid_q & ~cache_hit;
  assign lock_done   = (state_q == LOCKED) & (cache_refilled_hit | cache_uncached_done);
  assign pc_seq_d    = pc0_q + 32'd4;

  // Credit counts the in-flight F1 slot so a locked PC always finds room on completion.
  assign issue = resetn & (state_q == SEQ) &
                 (({1'b0, count_q} + (CW+1)'(f1_valid_q)) < (CW+1)'(QDEPTH));

  assign push    = ~redirect & (f1_hit | lock_done);
  assign pop     = ~redirect & o_ready & (count_q != '0);
  assign push_pc = lock_done ? pc0_q : f1_pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= SEQ;
      pc0_q            <= STARTUP_PC;
      f1_pc_q          <= '0;
      fid_q            <= '0;
      f1_fid_q         <= '0;
      f1_valid_q       <= 1'b0;
      cctrl_miss_q     <= 1'b0;
      cctrl_uncached_q <= 1'b0;
      q_bp_q           <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]  <= '0;
        q_fid_q[i] <= '0;
      end
    end else if (redirect) begin
      state_q          <= SEQ;
      pc0_q            <= redirect_pc;
      f1_valid_q       <= 1'b0;
      cctrl_miss_q     <= 1'b0;
      cctrl_uncached_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      if (push) begin
        q_pc_q[wr_ptr_q]  <= push_pc;
        q_fid_q[wr_ptr_q] <= f1_fid_q;
        q_bp_q[wr_ptr_q]  <= pred_taken;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);

      case (state_q)
        SEQ: begin
          if (f1_miss) begin
            // F1 fid stays in f1_fid_q for the eventual push; the same-cycle F0 issue is dropped.
            state_q          <= LOCKED;
            pc0_q            <= f1_pc_q;
            f1_valid_q       <= 1'b0;
            cctrl_miss_q     <= ~cache_uncached;
            cctrl_uncached_q <= cache_uncached;
          end else begin
            f1_valid_q <= issue;
            if (issue) begin
              f1_pc_q  <= pc0_q;
              f1_fid_q <= fid_q;
              fid_q    <= fid_q + 1'b1;
            end
            if (f1_hit && pred_taken) pc0_q <= bp_target;
            else if (issue)           pc0_q <= pc_seq_d;
          end
        end
        LOCKED: begin
          if (lock_done) begin
            state_q          <= SEQ;
            cctrl_miss_q     <= 1'b0;
            cctrl_uncached_q <= 1'b0;
            pc0_q            <= pred_taken ? bp_target : pc_seq_d;
          end
        end
        default: state_q <= SEQ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!resetn) !(push && count_q == CW'(QDEPTH)));

  // kseg0/kseg1 map to physical by dropping the top three bits; kseg1 is uncached.
  assign pc_vaddr       = pc0_q;
  assign pc_paddr       = (pc0_q[31:30] == 2'b10) ? {3'b000, pc0_q[28:0]} : pc0_q;
  assign pc_uncached    = (pc0_q[31:29] == 3'b101);
  assign pc_valid       = issue;
  assign cctrl_miss     = cctrl_miss_q;
  assign cctrl_uncached = cctrl_uncached_q;
  assign o_valid        = (count_q != '0);
  assign o_pc_vaddr     = q_pc_q[rd_ptr_q];
  assign o_pc_fid       = q_fid_q[rd_ptr_q];
  assign o_pc_bp_taken  = q_bp_q[rd_ptr_q];
  assign o_count        = count_q;

endmodule

// File: tb/tb_fetch_sequence_q.sv
// tb/tb_fetch_sequence_q.sv - self-checking bench for fetch_sequence_q
// Directed scenarios, a redirect/address-map table, and a random hit/miss/backpressure run.
module tb_fetch_sequence_q;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bco_valid, snoop_hit, cache_hit, cache_uncached;
  logic        cache_refilled_hit, cache_uncached_done;
  logic        bp_valid, bp_taken, bp_hit, o_ready;
  logic [31:0] bco_target, snoop_addr, bp_target;
  logic        cctrl_miss, cctrl_uncached, pc_uncached, pc_valid, o_valid, o_pc_bp_taken;
  logic [31:0] pc_vaddr, pc_paddr, o_pc_vaddr;
  logic [7:0]  o_pc_fid;
  logic [2:0]  o_count;

  always #5 clk = ~clk;

  fetch_sequence_q dut (
    .clk(clk), .resetn(resetn),
    .bco_valid(bco_valid), .bco_target(bco_target),
    .snoop_hit(snoop_hit), .snoop_addr(snoop_addr),
    .cache_hit(cache_hit), .cache_uncached(cache_uncached),
    .cache_refilled_hit(cache_refilled_hit), .cache_uncached_done(cache_uncached_done),
    .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_hit(bp_hit), .bp_target(bp_target),
    .cctrl_miss(cctrl_miss), .cctrl_uncached(cctrl_uncached),
    .pc_vaddr(pc_vaddr), .pc_paddr(pc_paddr), .pc_uncached(pc_uncached), .pc_valid(pc_valid),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc_vaddr(o_pc_vaddr), .o_pc_fid(o_pc_fid),
    .o_pc_bp_taken(o_pc_bp_taken), .o_count(o_count)
  );

  typedef struct { logic [31:0] pc; logic [7:0] fid; logic bp; } ent_t;
  typedef struct { logic [31:0] addr; logic [31:0] paddr; logic unc; } map_vec_t;

  ent_t got[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Records every entry that leaves the queue (pop happens on the following posedge).
  always @(negedge clk) begin
    #1;
    if (resetn && o_valid && o_ready && !snoop_hit && !bco_valid)
      got.push_back('{o_pc_vaddr, o_pc_fid, o_pc_bp_taken});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bco_valid = 0; bco_target = 0; snoop_hit = 0; snoop_addr = 0;
    cache_hit = 1; cache_uncached = 0; cache_refilled_hit = 0; cache_uncached_done = 0;
    bp_valid = 0; bp_taken = 0; bp_hit = 0; bp_target = 0; o_ready = 0;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    cyc(2);
    o_ready = rdy;
    got.delete();
    resetn = 1;
  endtask

  task automatic wait_issue(input logic [31:0] pc);
    int k = 0;
    while (!(pc_valid && pc_vaddr == pc) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_issue", 32'(pc_valid && pc_vaddr == pc), 32'd1);
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got.size() < n && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("wait_got", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string nm, input logic [31:0] pc0, input int n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({nm, "_pc"}, got[i].pc, pc0 + 32'(4 * i));
      chk({nm, "_fid"}, got[i].fid, 32'(i));
    end
  endtask

  map_vec_t    map_tab[6];
  logic [31:0] bp_exp[8];

  initial begin
    resetn = 0;
    idle_inputs();

    // 1: reset state, then one entry per cycle after two cycles of latency
    cyc(2);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_count", o_count, 0);
    chk("rst_cctrl_miss", cctrl_miss, 0);
    chk("rst_cctrl_unc", cctrl_uncached, 0);
    chk("rst_pc_valid", pc_valid, 0);
    chk("rst_pc_vaddr", pc_vaddr, 32'h8000_0000);
    chk("rst_pc_paddr", pc_paddr, 32'h0);
    chk("rst_o_pc", o_pc_vaddr, 32'h0);
    o_ready = 1;
    resetn  = 1;
    cyc(1);
    chk("t1_lat_valid", o_valid, 0);
    chk("t1_pc1", pc_vaddr, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t1_valid", o_valid, 1);
      chk("t1_pc", o_pc_vaddr, 32'h8000_0000 + 32'(4 * i));
      chk("t1_fid", o_pc_fid, 32'(i));
    end

    // 2: backpressure fills the queue and stops issue; release continues without gaps
    do_reset(0);
    cyc(12);
    chk("t2_count", o_count, 4);
    chk("t2_pc_valid", pc_valid, 0);
    chk("t2_o_valid", o_valid, 1);
    o_ready = 1;
    wait_got(8);
    check_seq("t2", 32'h8000_0000, 8);

    // 3: miss at 0x80000008, refill ten cycles later
    do_reset(0);
    wait_issue(32'h8000_0008);
    cyc(1); cache_hit = 0;
    cyc(1); cache_hit = 1;
    chk("t3_miss", cctrl_miss, 1);
    chk("t3_unc", cctrl_uncached, 0);
    chk("t3_pc_valid", pc_valid, 0);
    chk("t3_pc_vaddr", pc_vaddr, 32'h8000_0008);
    cyc(9);
    chk("t3_miss_held", cctrl_miss, 1);
    chk("t3_count_lock", o_count, 2);
    cache_refilled_hit = 1;
    cyc(1); cache_refilled_hit = 0;
    chk("t3_miss_clr", cctrl_miss, 0);
    chk("t3_count_done", o_count, 3);
    o_ready = 1;
    wait_got(6);
    check_seq("t3", 32'h8000_0000, 6);

    // 4: predicted-taken branch at 0x80000010 keeps its delay slot
    do_reset(1);
    wait_issue(32'h8000_0010);
    cyc(1);
    bp_valid = 1; bp_hit = 1; bp_taken = 1; bp_target = 32'h8000_1000;
    cyc(1);
    bp_valid = 0; bp_hit = 0; bp_taken = 0;
    wait_got(8);
    bp_exp = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
               32'h8000_0010, 32'h8000_0014, 32'h8000_1000, 32'h8000_1004};
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("t4_pc", got[i].pc, bp_exp[i]);
      chk("t4_fid", got[i].fid, 32'(i));
      chk("t4_bp", got[i].bp, 32'(i == 4));
    end

    // 5: commit override while locked with three queued entries
    do_reset(0);
    wait_issue(32'h8000_000C);
    cyc(1); cache_hit = 0;
    cyc(1); cache_hit = 1;
    chk("t5_miss", cctrl_miss, 1);
    chk("t5_count", o_count, 3);
    cyc(3);
    bco_valid = 1; bco_target = 32'h8000_2000;
    cyc(1); bco_valid = 0;
    chk("t5_o_valid", o_valid, 0);
    chk("t5_count0", o_count, 0);
    chk("t5_miss_clr", cctrl_miss, 0);
    chk("t5_unc_clr", cctrl_uncached, 0);
    chk("t5_pc_vaddr", pc_vaddr, 32'h8000_2000);
    chk("t5_pc_valid", pc_valid, 1);
    got.delete();
    o_ready = 1;
    wait_got(2);
    if (got.size() >= 2) begin
      chk("t5_pc0", got[0].pc, 32'h8000_2000);
      chk("t5_fid0", got[0].fid, 4);
      chk("t5_pc1", got[1].pc, 32'h8000_2004);
      chk("t5_fid1", got[1].fid, 5);
    end

    // 6: snoop beats bco; kseg1 fetch goes uncached; reset lands mid-lock
    do_reset(1);
    snoop_hit = 1; snoop_addr = 32'hBFC0_0000;
    bco_valid = 1; bco_target = 32'h8000_2000;
    cyc(1);
    snoop_hit = 0; bco_valid = 0;
    chk("t6_pc_vaddr", pc_vaddr, 32'hBFC0_0000);
    chk("t6_uncached", pc_uncached, 1);
    chk("t6_paddr", pc_paddr, 32'h1FC0_0000);
    chk("t6_pc_valid", pc_valid, 1);
    cyc(1); cache_hit = 0; cache_uncached = 1;
    cyc(1); cache_hit = 1; cache_uncached = 0;
    chk("t6_cc_unc", cctrl_uncached, 1);
    chk("t6_cc_miss", cctrl_miss, 0);
    got.delete();
    cyc(3);
    cache_uncached_done = 1;
    cyc(1); cache_uncached_done = 0;
    chk("t6_unc_clr", cctrl_uncached, 0);
    wait_got(2);
    if (got.size() >= 2) begin
      chk("t6_got0", got[0].pc, 32'hBFC0_0000);
      chk("t6_got1", got[1].pc, 32'hBFC0_0004);
    end
    wait_issue(32'hBFC0_0010);
    cyc(1); cache_hit = 0;
    cyc(1); cache_hit = 1;
    chk("t6_lock2", cctrl_miss, 1);
    cyc(2);
    resetn = 0;
    #1;
    chk("t6_rst_miss", cctrl_miss, 0);
    chk("t6_rst_unc", cctrl_uncached, 0);
    chk("t6_rst_pc", pc_vaddr, 32'h8000_0000);
    chk("t6_rst_count", o_count, 0);
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_pcv", pc_valid, 0);

    // Redirect address map table
    map_tab[0] = '{32'hBFC0_0000, 32'h1FC0_0000, 1'b1};
    map_tab[1] = '{32'h8000_1234, 32'h0000_1234, 1'b0};
    map_tab[2] = '{32'h0040_0000, 32'h0040_0000, 1'b0};
    map_tab[3] = '{32'hA000_0000, 32'h0000_0000, 1'b1};
    map_tab[4] = '{32'hC000_0000, 32'hC000_0000, 1'b0};
    map_tab[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      bco_valid = 1; bco_target = map_tab[i].addr;
      cyc(1); bco_valid = 0;
      chk("map_vaddr", pc_vaddr, map_tab[i].addr);
      chk("map_paddr", pc_paddr, map_tab[i].paddr);
      chk("map_unc", pc_uncached, 32'(map_tab[i].unc));
      chk("map_flush", o_valid, 0);
      cyc(2);
    end

    // PC wraps at 2^32
    bco_valid = 1; bco_target = 32'hFFFF_FFF8;
    cyc(1); bco_valid = 0;
    got.delete();
    wait_got(3);
    if (got.size() >= 3) begin
      chk("wrap0", got[0].pc, 32'hFFFF_FFF8);
      chk("wrap1", got[1].pc, 32'hFFFF_FFFC);
      chk("wrap2", got[2].pc, 32'h0000_0000);
    end

    // Random hits/misses/uncached/backpressure: output must be the plain sequential stream
    begin
      int   exp_idx   = 0;
      int   lat       = 0;
      logic done_sent = 0;
      do_reset(1);
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        o_ready             = ($urandom % 4) != 0;
        cache_hit           = ($urandom % 8) != 0;
        cache_uncached      = $urandom % 2;
        cache_refilled_hit  = 0;
        cache_uncached_done = 0;
        if (!cctrl_miss && !cctrl_uncached) begin
          done_sent = 0;
          lat       = $urandom_range(0, 6);
        end else if (!done_sent) begin
          if (lat == 0) begin
            if (cctrl_uncached) cache_uncached_done = 1;
            else                cache_refilled_hit  = 1;
            done_sent = 1;
          end else lat--;
        end
        #1;
        chk("rnd_excl", 32'(cctrl_miss && cctrl_uncached), 0);
        chk("rnd_count_le", 32'(o_count <= 3'd4), 1);
        if (o_valid && o_ready) begin
          chk("rnd_pc", o_pc_vaddr, 32'h8000_0000 + 32'(4 * exp_idx));
          chk("rnd_fid", o_pc_fid, 32'(exp_idx % 256));
          exp_idx++;
        end
      end
      chk("rnd_progress", 32'(exp_idx >= 300), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
